// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-port arbiter for the shared combinational ROM read port
// One response outstanding at a time; each response is held until its requester consumes it.
module rom_port_arbiter #(
  parameter int DEPTH       = 512,
  parameter int ROUND_ROBIN = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_error,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_error,
  input  logic        rsp1_ready,
  output logic [31:0] rom_read_address,
  input  logic [31:0] rom_read_data,
  input  logic        rom_illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_e;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);
  localparam bit          USE_RR     = (ROUND_ROBIN != 0);
  localparam bit          USE_ALIGN  = (CHECK_ALIGN != 0);

  state_e      state_q;
  logic        last_grant_q;
  logic [31:0] rsp0_data_q;
  logic [31:0] rsp1_data_q;
  logic        rsp0_error_q;
  logic        rsp1_error_q;

  logic        grant;
  logic        can_issue;
  logic [31:0] sel_addr;
  logic        addr_error;
  logic        accept0;
  logic        accept1;

  // grant is 0 when nobody requests; ready is additionally qualified by valid
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      if (USE_RR) begin
        grant = ~last_grant_q;
      end
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_issue = (state_q == IDLE)
                   | ((state_q == HOLD0) & rsp0_ready)
                   | ((state_q == HOLD1) & rsp1_ready);

  assign req0_ready = can_issue & req0_valid & ~grant;
  assign req1_ready = can_issue & req1_valid & grant;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;

  assign sel_addr         = grant ? req1_addr : req0_addr;
  assign rom_read_address = (req0_valid | req1_valid) ? sel_addr : 32'd0;

  assign addr_error = rom_illegal
                    | ({1'b0, sel_addr} >= ADDR_LIMIT)
                    | (USE_ALIGN & (|sel_addr[1:0]));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
      rsp0_error_q <= 1'b0;
      rsp1_error_q <= 1'b0;
    end else if (accept0) begin
      rsp0_data_q  <= rom_read_data;
      rsp0_error_q <= addr_error;
      state_q      <= HOLD0;
      last_grant_q <= 1'b0;
    end else if (accept1) begin
      rsp1_data_q  <= rom_read_data;
      rsp1_error_q <= addr_error;
      state_q      <= HOLD1;
      last_grant_q <= 1'b1;
    end else if (can_issue) begin
      state_q <= IDLE;
    end
  end

  assign rsp0_valid = (state_q == HOLD0);
  assign rsp1_valid = (state_q == HOLD1);
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp0_error = rsp0_error_q;
  assign rsp1_error = rsp1_error_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - checks rom_port_arbiter in round-robin/aligned and fixed/unaligned builds
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic        rsp_ready [2];

  logic        req_ready [2][2];
  logic        rsp_valid [2][2];
  logic [31:0] rsp_data  [2][2];
  logic        rsp_error [2][2];
  logic [31:0] rom_addr  [2];
  logic [31:0] rom_data  [2];
  logic        rom_ill   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'd7 + 32'd3;
    return t[7:0];
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {rom_byte(a + 32'd3), rom_byte(a + 32'd2), rom_byte(a + 32'd1), rom_byte(a)};
  endfunction

  function automatic logic rom_flag(input logic [31:0] a);
    return (a / 4) == 32'd100;
  endfunction

  assign rom_data[0] = rom_word(rom_addr[0]);
  assign rom_data[1] = rom_word(rom_addr[1]);
  assign rom_ill[0]  = rom_flag(rom_addr[0]);
  assign rom_ill[1]  = rom_flag(rom_addr[1]);

  rom_port_arbiter #(.DEPTH(512), .ROUND_ROBIN(1), .CHECK_ALIGN(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_addr(req_addr[0]), .req0_ready(req_ready[0][0]),
    .rsp0_valid(rsp_valid[0][0]), .rsp0_data(rsp_data[0][0]), .rsp0_error(rsp_error[0][0]),
    .rsp0_ready(rsp_ready[0]),
    .req1_valid(req_valid[1]), .req1_addr(req_addr[1]), .req1_ready(req_ready[0][1]),
    .rsp1_valid(rsp_valid[0][1]), .rsp1_data(rsp_data[0][1]), .rsp1_error(rsp_error[0][1]),
    .rsp1_ready(rsp_ready[1]),
    .rom_read_address(rom_addr[0]), .rom_read_data(rom_data[0]), .rom_illegal(rom_ill[0])
  );

  rom_port_arbiter #(.DEPTH(512), .ROUND_ROBIN(0), .CHECK_ALIGN(0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_addr(req_addr[0]), .req0_ready(req_ready[1][0]),
    .rsp0_valid(rsp_valid[1][0]), .rsp0_data(rsp_data[1][0]), .rsp0_error(rsp_error[1][0]),
    .rsp0_ready(rsp_ready[0]),
    .req1_valid(req_valid[1]), .req1_addr(req_addr[1]), .req1_ready(req_ready[1][1]),
    .rsp1_valid(rsp_valid[1][1]), .rsp1_data(rsp_data[1][1]), .rsp1_error(rsp_error[1][1]),
    .rsp1_ready(rsp_ready[1]),
    .rom_read_address(rom_addr[1]), .rom_read_data(rom_data[1]), .rom_illegal(rom_ill[1])
  );

  // reference model: one outstanding response per instance, plus who was served last
  bit          m_rr    [2] = '{1'b1, 1'b0};
  bit          m_align [2] = '{1'b1, 1'b0};
  bit          m_has   [2];
  int          m_port  [2];
  int          m_last  [2];
  logic [31:0] m_data  [2][2];
  bit          m_err   [2][2];
  bit          last_acc[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_has[d]  = 1'b0;
      m_port[d] = 0;
      m_last[d] = 1;
      for (int k = 0; k < 2; k++) begin
        m_data[d][k] = 32'd0;
        m_err[d][k]  = 1'b0;
      end
    end
  endtask

  task automatic model_cycle();
    for (int d = 0; d < 2; d++) begin
      int  win;
      bit  can;
      bit  exp_rdy [2];
      logic [31:0] a;
      if (req_valid[0] && req_valid[1]) win = m_rr[d] ? 1 - m_last[d] : 0;
      else if (req_valid[0])            win = 0;
      else if (req_valid[1])            win = 1;
      else                              win = -1;
      can = !m_has[d] || rsp_ready[m_port[d]];
      for (int k = 0; k < 2; k++) begin
        exp_rdy[k] = can && (win == k);
        check($sformatf("dut%0d req%0d_ready", d, k), 32'(req_ready[d][k]), 32'(exp_rdy[k]));
        check($sformatf("dut%0d rsp%0d_valid", d, k), 32'(rsp_valid[d][k]),
              32'(m_has[d] && m_port[d] == k));
        if (m_has[d] && m_port[d] == k) begin
          check($sformatf("dut%0d rsp%0d_data", d, k), rsp_data[d][k], m_data[d][k]);
          check($sformatf("dut%0d rsp%0d_error", d, k), 32'(rsp_error[d][k]), 32'(m_err[d][k]));
        end
      end
      check($sformatf("dut%0d rom_addr", d), rom_addr[d], (win < 0) ? 32'd0 : req_addr[win]);
      if (win >= 0 && exp_rdy[win]) begin
        a = req_addr[win];
        m_data[d][win] = rom_word(a);
        m_err[d][win]  = rom_flag(a) || (a >= 32'd2048) || (m_align[d] && (a % 4) != 0);
        m_has[d]  = 1'b1;
        m_port[d] = win;
        m_last[d] = win;
      end else if (m_has[d] && rsp_ready[m_port[d]]) begin
        m_has[d] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) last_acc[k] = req_valid[k] && req_ready[0][k];
  endtask

  task automatic set_in(input bit v0, input logic [31:0] a0, input bit v1, input logic [31:0] a1,
                        input bit r0, input bit r1);
    req_valid[0] = v0; req_addr[0] = a0;
    req_valid[1] = v1; req_addr[1] = a1;
    rsp_ready[0] = r0; rsp_ready[1] = r1;
  endtask

  task automatic finish_cycle();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    last_acc[0] = 1'b0;
    last_acc[1] = 1'b0;
  endtask

  typedef struct {
    bit          v0;
    logic [31:0] a0;
    bit          v1;
    logic [31:0] a1;
    bit          r0;
    bit          r1;
    logic [1:0]  rdy_a;
    logic [1:0]  rdy_b;
    logic [1:0]  rv_a;
    logic [1:0]  err_a;
    logic [31:0] d0a;
  } vec_t;

  function automatic vec_t mk(input bit v0, input logic [31:0] a0, input bit v1,
                              input logic [31:0] a1, input bit r0, input bit r1,
                              input logic [1:0] rdy_a, input logic [1:0] rdy_b,
                              input logic [1:0] rv_a, input logic [1:0] err_a,
                              input logic [31:0] d0a);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.r0 = r0; v.r1 = r1;
    v.rdy_a = rdy_a; v.rdy_b = rdy_b; v.rv_a = rv_a; v.err_a = err_a; v.d0a = d0a;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {21'd0, 9'($urandom_range(0, 511)), 2'b00};
      1:       return 32'($urandom_range(0, 2047));
      2:       return 32'h190 + 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl [9];

  initial begin
    tbl[0] = mk(0, 32'h0,  0, 32'h0,   0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0);
    tbl[1] = mk(1, 32'h10, 0, 32'h0,   0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h0);
    tbl[2] = mk(0, 32'h0,  0, 32'h0,   0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 32'h10);
    tbl[3] = mk(1, 32'h20, 1, 32'h800, 1, 0, 2'b10, 2'b01, 2'b01, 2'b00, 32'h10);
    tbl[4] = mk(1, 32'h20, 1, 32'h6,   1, 1, 2'b01, 2'b01, 2'b10, 2'b10, 32'h0);
    tbl[5] = mk(1, 32'h24, 1, 32'h6,   1, 1, 2'b10, 2'b01, 2'b01, 2'b00, 32'h20);
    tbl[6] = mk(0, 32'h0,  0, 32'h0,   0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0);
    tbl[7] = mk(0, 32'h0,  0, 32'h0,   0, 1, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0);
    tbl[8] = mk(0, 32'h0,  0, 32'h0,   0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0);

    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    #1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2; k++) begin
        check($sformatf("reset dut%0d rsp%0d_data", d, k), rsp_data[d][k], 32'd0);
        check($sformatf("reset dut%0d rsp%0d_error", d, k), 32'(rsp_error[d][k]), 32'd0);
      end
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, tbl[i].r0, tbl[i].r1);
      #1;
      check($sformatf("vec%0d rdy_a", i), 32'({req_ready[0][1], req_ready[0][0]}), 32'(tbl[i].rdy_a));
      check($sformatf("vec%0d rdy_b", i), 32'({req_ready[1][1], req_ready[1][0]}), 32'(tbl[i].rdy_b));
      check($sformatf("vec%0d rv_a", i), 32'({rsp_valid[0][1], rsp_valid[0][0]}), 32'(tbl[i].rv_a));
      for (int k = 0; k < 2; k++)
        if (tbl[i].rv_a[k])
          check($sformatf("vec%0d err%0d_a", i, k), 32'(rsp_error[0][k]), 32'(tbl[i].err_a[k]));
      if (tbl[i].rv_a[0])
        check($sformatf("vec%0d data0_a", i), rsp_data[0][0], rom_word(tbl[i].d0a));
      finish_cycle();
    end

    // misaligned address is an error only in the aligned build
    do_reset();
    set_in(0, 0, 1, 32'h6, 0, 0);
    #1;
    finish_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check("align err dut_a", 32'(rsp_error[0][1]), 32'd1);
    check("align err dut_b", 32'(rsp_error[1][1]), 32'd0);
    finish_cycle();

    // back-pressure: port 0 response held while both ports request
    do_reset();
    set_in(1, 32'h40, 0, 0, 0, 0);
    #1;
    finish_cycle();
    for (int c = 0; c < 5; c++) begin
      set_in(1, 32'h44, 1, 32'h80, 0, 0);
      #1;
      check("bp ready_a", 32'({req_ready[0][1], req_ready[0][0]}), 32'd0);
      check("bp data0_a", rsp_data[0][0], rom_word(32'h40));
      finish_cycle();
    end
    set_in(1, 32'h44, 1, 32'h80, 1, 0);
    #1;
    check("bp release rdy1_a", 32'(req_ready[0][1]), 32'd1);
    finish_cycle();
    set_in(1, 32'h44, 0, 0, 0, 0);
    #1;
    check("bp rsp1_valid_a", 32'(rsp_valid[0][1]), 32'd1);
    // reset while HOLD1: the response is dropped and port 0 wins next
    reset_n = 1'b0;
    set_in(1, 32'h44, 1, 32'h84, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
    check("post-reset rsp1_valid_a", 32'(rsp_valid[0][1]), 32'd0);
    check("post-reset grant_a", 32'({req_ready[0][1], req_ready[0][0]}), 32'd1);
    finish_cycle();

    // randomized traffic against the model
    set_in(0, 0, 0, 0, 0, 0);
    last_acc[0] = 1'b0;
    last_acc[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        set_in(0, 0, 0, 0, 0, 0);
        do_reset();
      end
      for (int k = 0; k < 2; k++) begin
        if (!(req_valid[k] && !last_acc[k])) begin
          req_valid[k] = ($urandom_range(0, 99) < 60);
          req_addr[k]  = rand_addr();
        end
        rsp_ready[k] = ($urandom_range(0, 99) < 60);
      end
      #1;
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
